mmh3_arb: RTL and testbench

MMH3_ARB -- requirements
Module: mmh3_arb

---
 rtl/mmh3_arb.sv | 229 ++++++++++++++++++++++
 tb/tb_mmh3_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmh3_arb.sv
`default_nettype none
// ============================================================================
// Module   : mmh3_arb
// Brief    : Round-robin arbiter sharing one fixed-latency, non-stallable hash
//            pipeline; tags track issues, results return in order via a FIFO.
// Revision : 1.0
// ============================================================================
module mmh3_arb #(
    parameter int N_REQ      = 4,
    parameter int LATENCY    = 18,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*62-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [61:0]              hash_in_data,
    output logic                     hash_in_valid,
    input  logic [63:0]              hash_out,
    input  logic                     hash_out_valid,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [63:0]              res_hash,
    output logic                     busy,
    output logic                     err
);
    localparam int c_ID_W  = $clog2(N_REQ);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_SUM_W = c_CNT_W + 1;
    localparam int c_DRN_W = $clog2(LATENCY + 1);

    localparam logic [c_DRN_W-1:0] c_DRAIN_LAST = c_DRN_W'(LATENCY);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST   = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_SUM_W-1:0] c_CREDIT_MAX = c_SUM_W'(FIFO_DEPTH);
    localparam logic [c_ID_W-1:0]  c_ID_LAST    = c_ID_W'(N_REQ - 1);

    localparam logic [0:0] c_ST_DRAIN = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_DRN_W-1:0] r_drain_cnt;
    logic               w_run;

    logic [c_ID_W-1:0]  r_last_grant;
    logic [c_ID_W-1:0]  w_cand;
    logic [c_ID_W-1:0]  w_grant_idx;
    logic               w_found;
    logic               w_credit;
    logic               w_hs;
    logic [c_SUM_W-1:0] w_occ;

    logic [61:0]        r_hash_in_data;
    logic               r_hash_in_valid;

    logic               r_tag_v  [LATENCY+1];
    logic [c_ID_W-1:0]  r_tag_id [LATENCY+1];
    logic               w_tag_v;
    logic [c_ID_W-1:0]  w_tag_id;

    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_fifo_cnt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_ID_W+63:0] r_mem [FIFO_DEPTH];
    logic [c_ID_W+63:0] w_head;
    logic               w_fifo_wr;
    logic               w_fifo_rd;
    logic               r_err;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_DRAIN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    // DRAIN covers LATENCY+1 cycles so every pre-reset pipeline output is absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == c_ST_DRAIN && r_drain_cnt != c_DRAIN_LAST) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    assign w_run = (r_state == c_ST_RUN);

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = c_ID_W'((int'(r_last_grant) + k) % N_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_occ    = c_SUM_W'(r_fifo_cnt) + c_SUM_W'(r_inflight);
    assign w_credit = (w_occ < c_CREDIT_MAX);
    assign w_hs     = w_run & w_credit & w_found;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hash_in_valid <= 1'b0;
            r_hash_in_data  <= '0;
            r_last_grant    <= c_ID_LAST;
        end else begin
            r_hash_in_valid <= w_hs;
            if (w_hs) begin
                r_hash_in_data <= req_data[62*w_grant_idx +: 62];
                r_last_grant   <= w_grant_idx;
            end
        end
    end

    assign hash_in_data  = r_hash_in_data;
    assign hash_in_valid = r_hash_in_valid;

    // ---------------------------------------------------------------- tags
    // Stage 0 is loaded with the issue edge, so stage LATENCY meets hash_out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= LATENCY; s++) begin
                r_tag_v[s]  <= 1'b0;
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_hs;
            r_tag_id[0] <= w_grant_idx;
            for (int s = 1; s <= LATENCY; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    assign w_tag_v   = r_tag_v[LATENCY];
    assign w_tag_id  = r_tag_id[LATENCY];
    assign w_fifo_wr = w_run & hash_out_valid & w_tag_v;
    assign w_fifo_rd = res_valid & res_ready;

    // A tag always retires, with or without a matching hash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_hs, w_tag_v})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_fifo_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= {w_tag_id, hash_out};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign res_valid = (r_fifo_cnt != '0);
    assign res_id    = res_valid ? w_head[c_ID_W+63:64] : '0;
    assign res_hash  = res_valid ? w_head[63:0] : '0;

    // ---------------------------------------------------------------- status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_run && (hash_out_valid != w_tag_v)) begin
            r_err <= 1'b1;
        end
    end

    assign err  = r_err;
    assign busy = (r_inflight != '0) | (r_fifo_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_mmh3_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmh3_arb
// Brief    : Scoreboard bench for mmh3_arb with a behavioural fmix64 pipeline.
// Revision : 1.0
// ============================================================================
module tb_mmh3_arb;
    localparam int N_REQ      = 4;
    localparam int LATENCY    = 18;
    localparam int FIFO_DEPTH = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ*62-1:0] req_data = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [61:0]         hash_in_data;
    logic                hash_in_valid;
    logic [63:0]         hash_out;
    logic                hash_out_valid;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic [1:0]          res_id;
    logic [63:0]         res_hash;
    logic                busy;
    logic                err;

    logic [N_REQ-1:0]    valid_mask = '0;
    logic                rand_mode = 1'b0;
    logic                rr_rand = 1'b0;
    logic                rr_fixed = 1'b1;
    logic                key_zero = 1'b0;
    logic                inj = 1'b0;

    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  n_grants = 0;
    int                  n_pops = 0;
    int                  m_last = N_REQ - 1;
    logic [65:0]         sb_q[$];

    logic                pv [LATENCY] = '{default: 1'b0};
    logic [63:0]         pd [LATENCY] = '{default: 64'd0};

    always #5 clk = ~clk;

    mmh3_arb #(.N_REQ(N_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .hash_in_data(hash_in_data), .hash_in_valid(hash_in_valid),
        .hash_out(hash_out), .hash_out_valid(hash_out_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_hash(res_hash),
        .busy(busy), .err(err)
    );

    function automatic logic [63:0] fmix64(input logic [63:0] k_in);
        logic [63:0] k;
        k = k_in;
        k = k ^ (k >> 33);
        k = k * 64'hff51afd7ed558ccd;
        k = k ^ (k >> 33);
        k = k * 64'hc4ceb9fe1a85ec53;
        k = k ^ (k >> 33);
        return k;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Hash pipeline model; deliberately not reset so it keeps emitting across rst
    always @(posedge clk) begin
        pv[0] <= hash_in_valid;
        pd[0] <= fmix64({2'b00, hash_in_data});
        for (int s = 1; s < LATENCY; s++) begin
            pv[s] <= pv[s-1];
            pd[s] <= pd[s-1];
        end
    end
    assign hash_out       = pd[LATENCY-1];
    assign hash_out_valid = pv[LATENCY-1] | inj;

    // Input driver
    initial begin
        logic [63:0] r64;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                r64 = {$urandom, $urandom};
                req_valid[i] = rand_mode ? 1'($urandom_range(0, 1)) : valid_mask[i];
                req_data[62*i +: 62] = key_zero ? 62'd0 : r64[61:0];
            end
            res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
        end
    end

    // Monitor: grant model + scoreboard push on handshake, pop on result
    initial begin
        int          e;
        logic [61:0] key;
        logic [65:0] item;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                m_last = N_REQ - 1;
            end else begin
                chk("ready_onehot_subset", (req_ready & (req_ready - 1'b1)) | (req_ready & ~req_valid), 0);
                if (req_ready != '0) begin
                    e = rr_pick(req_valid, m_last);
                    chk("rr_grant", req_ready, (e < 0) ? 0 : (1 << e));
                    chk("grant_credit", sb_q.size() < FIFO_DEPTH, 1);
                    if (e >= 0) begin
                        key = req_data[62*e +: 62];
                        sb_q.push_back({2'(e), fmix64({2'b00, key})});
                        m_last = e;
                    end
                    n_grants++;
                end
                if (res_valid && res_ready) begin
                    n_pops++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        item = sb_q.pop_front();
                        chk("res_id", res_id, item[65:64]);
                        chk("res_hash", res_hash, item[63:0]);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input logic exp_err);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy || res_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 300, 1);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("err_state", err, exp_err);
    endtask

    initial begin
        int lat, gaps, late, g0, p0;
        logic resumed;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_hash_in_data", hash_in_data, 0);
        chk("rst_hash_in_valid", hash_in_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_hash", res_hash, 0);

        // Single zero key from requester 2, held through DRAIN
        key_zero   = 1'b1;
        valid_mask = 4'b0100;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (LATENCY + 1) begin
            @(negedge clk);
            chk("drain_ready_blocked", req_ready, 0);
            chk("drain_no_issue", hash_in_valid, 0);
        end
        @(negedge clk);
        chk("first_run_ready", req_ready, 4'b0100);
        valid_mask = '0;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("issue_to_result_latency", lat, LATENCY + 2);
        chk("zero_key_id", res_id, 2);
        chk("zero_key_hash", res_hash, 64'h0);
        key_zero = 1'b0;
        wait_idle(1'b0);

        // All requesters streaming
        valid_mask = 4'hF;
        gaps = 0;
        late = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (req_ready == '0) gaps++;
            if (c >= 22 && !res_valid) late++;
        end
        chk("stream_grant_gaps", gaps, 0);
        chk("stream_result_gaps", late, 0);
        valid_mask = '0;
        wait_idle(1'b0);

        // Back-pressure: credit fills the FIFO exactly
        rr_fixed   = 1'b0;
        valid_mask = 4'b0001;
        g0 = n_grants;
        repeat (80) @(negedge clk);
        chk("full_grant_count", n_grants - g0, FIFO_DEPTH);
        chk("full_ready_low", req_ready, 0);
        chk("full_res_valid", res_valid, 1);
        p0 = n_pops;
        rr_fixed = 1'b1;
        resumed  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (req_ready != '0) resumed = 1'b1;
        end
        chk("full_pops", (n_pops - p0) >= FIFO_DEPTH, 1);
        chk("grants_resume", resumed, 1);
        valid_mask = '0;
        wait_idle(1'b0);

        // Reset with items in flight
        valid_mask = 4'hF;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (LATENCY + 1) begin
            @(negedge clk);
            chk("midrst_res_valid", res_valid, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_err", err, 0);
            chk("midrst_ready", req_ready, 0);
        end
        repeat (30) @(negedge clk);
        valid_mask = '0;
        wait_idle(1'b0);

        // Random traffic on all ports
        rand_mode = 1'b1;
        rr_rand   = 1'b1;
        repeat (20000) @(negedge clk);
        rand_mode = 1'b0;
        rr_rand   = 1'b0;
        rr_fixed  = 1'b1;
        valid_mask = '0;
        wait_idle(1'b0);

        // Tagless hash pulse while results sit in the FIFO
        rr_fixed   = 1'b0;
        valid_mask = 4'b0001;
        repeat (6) @(negedge clk);
        valid_mask = '0;
        repeat (40) @(negedge clk);
        chk("pre_inject_res_valid", res_valid, 1);
        chk("pre_inject_err", err, 0);
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        repeat (5) @(negedge clk);
        chk("inject_err", err, 1);
        rr_fixed = 1'b1;
        wait_idle(1'b1);
        repeat (10) @(negedge clk);
        chk("err_sticky", err, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_clears_err", err, 0);
        chk("reset_clears_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
